dds_wr_arbiter: RTL and testbench

//  Shares the single DDS register-access port (wr_start/wr_addr/wr_data/wr_done/wr_out)

---
 rtl/dds_bus_pkg.sv | 8 +
 rtl/dds_wr_arbiter_if.sv | 12 +
 rtl/dds_wr_arbiter_rr_pick.sv | 24 ++
 rtl/dds_wr_arbiter.sv | 86 ++++++++
 tb/tb_dds_wr_arbiter.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dds_bus_pkg.sv
// dds_bus_pkg: DDS register bus widths and FSM encoding shared by the
// DDS writer, the sequencer and the write arbiter.
package dds_bus_pkg;
    localparam int DDS_AW     = 8;
    localparam int DDS_DW     = 32;
    localparam int DDS_RD_BIT = 7;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
endpackage

// File: rtl/dds_wr_arbiter_if.sv
// dds_wr_arbiter_if: register-access port between the arbiter and the DDS serial writer
interface dds_wr_arbiter_if
    import dds_bus_pkg::*;
;
    logic              wr_start;
    logic [DDS_AW-1:0] wr_addr;
    logic [DDS_DW-1:0] wr_data;
    logic              wr_done;
    logic [DDS_DW-1:0] wr_out;
    modport master(output wr_start, wr_addr, wr_data, input wr_done, wr_out);
    modport slave(input wr_start, wr_addr, wr_data, output wr_done, wr_out);
endinterface

// File: rtl/dds_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search with optional strict priority for requester 0
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            pri0,
    output logic [IDW-1:0]  win,
    output logic            vld
);
    int idx;
    always_comb begin
        win = '0;
        idx = 0;
        // descending scan so the nearest set request after ptr is written last
        for (int i = NREQ; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NREQ;
            if (req[idx]) win = IDW'(idx);
        end
        if (pri0 && req[0]) win = '0;
    end
    assign vld = |req;
endmodule

// File: rtl/dds_wr_arbiter.sv
// dds_wr_arbiter: shares the DDS register writer between NREQ requesters,
// one transaction at a time, with a watchdog on the writer's completion.
module dds_wr_arbiter
    import dds_bus_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 1023,
    parameter int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DDS_AW-1:0] req_addr,
    input  logic [NREQ*DDS_DW-1:0] req_data,
    input  logic                   pri0,
    output logic [NREQ-1:0]        ack,
    output logic [DDS_DW-1:0]      rsp_data,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [IDW-1:0]         owner,
    dds_wr_arbiter_if.master       wr
);
    localparam int TW = $clog2(TIMEOUT + 1);
    state_e         st, st_n;
    logic [TW-1:0]  tmr;
    logic [IDW-1:0] ptr, win;
    logic           win_v, to;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req (req),
        .ptr (ptr),
        .pri0(pri0),
        .win (win),
        .vld (win_v)
    );

    // a completion in the timeout cycle takes precedence over the error
    assign to = st == WAIT && !wr.wr_done && tmr == TW'(TIMEOUT - 1);

    always_comb begin
        st_n = st;
        case (st)
            IDLE:  st_n = win_v ? ISSUE : IDLE;
            ISSUE: st_n = WAIT;
            WAIT:  st_n = (wr.wr_done || to) ? DONE : WAIT;
            DONE:  st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) st <= IDLE;
        else st <= st_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= IDW'(NREQ - 1);
            owner       <= '0;
            tmr         <= '0;
            ack         <= '0;
            busy        <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            wr.wr_start <= 1'b0;
            wr.wr_addr  <= '0;
            wr.wr_data  <= '0;
        end else begin
            wr.wr_start <= st_n == ISSUE;
            busy        <= st_n != IDLE;
            ack         <= (st == WAIT && st_n == DONE) ? {{(NREQ-1){1'b0}}, 1'b1} << owner : '0;
            tmr         <= (st == WAIT) ? tmr + 1'b1 : '0;
            if (st == IDLE && win_v) begin
                owner      <= win;
                ptr        <= win;
                wr.wr_addr <= req_addr[win*DDS_AW +: DDS_AW];
                wr.wr_data <= req_data[win*DDS_DW +: DDS_DW];
            end
            if (st == WAIT && wr.wr_done) begin
                rsp_data <= wr.wr_addr[DDS_RD_BIT] ? wr.wr_out : '0;
                rsp_err  <= 1'b0;
            end else if (to) begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_dds_wr_arbiter.sv
// tb_dds_wr_arbiter: scoreboard bench; stimulus queues expected transactions,
// a monitor checks them at wr_start and at each ack pulse.
module tb_dds_wr_arbiter;
    typedef struct {
        int          own;
        logic [7:0]  a;
        logic [31:0] d;
        int          dly;
        logic [31:0] wo;
        logic [31:0] rsp;
        logic        err;
        int          off;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [15:0] req_addr = '0;
    logic [63:0] req_data = '0;
    logic        pri0 = 1'b0;
    logic [1:0]  ack;
    logic [31:0] rsp_data;
    logic        rsp_err, busy;
    logic [0:0]  owner;
    int          cyc = 0;
    int          checks = 0;
    int          passed = 0;
    exp_t        q[$];

    dds_wr_arbiter_if wr();

    dds_wr_arbiter #(.NREQ(2), .TIMEOUT(15)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .req_addr(req_addr),
        .req_data(req_data),
        .pri0    (pri0),
        .ack     (ack),
        .rsp_data(rsp_data),
        .rsp_err (rsp_err),
        .busy    (busy),
        .owner   (owner),
        .wr      (wr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic push(input int own, input logic [7:0] a, input logic [31:0] d, input int dly,
                        input logic [31:0] wo, input logic [31:0] rsp, input logic err);
        exp_t e;
        e = '{own, a, d, dly, wo, rsp, err, (dly < 0) ? 16 : dly + 1};
        q.push_back(e);
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ack == 2'b00 && n < 100);
        if (ack == 2'b00) begin
            checks++;
            $display("FAIL ack_timeout: no ack within %0d cycles", n);
        end
    endtask

    // DDS writer model: answers each wr_start after the queued delay (negative = never)
    initial begin
        wr.wr_done = 1'b0;
        wr.wr_out  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && wr.wr_start && q.size() != 0 && q[0].dly > 0) begin
                int          dl;
                logic [31:0] wo;
                dl = q[0].dly;
                wo = q[0].wo;
                repeat (dl) @(negedge clk);
                wr.wr_done = 1'b1;
                wr.wr_out  = wo;
                @(negedge clk);
                wr.wr_done = 1'b0;
                wr.wr_out  = '0;
            end
        end
    end

    // monitor / scoreboard
    initial begin
        int          t_start = 0;
        bit          st_next = 0, ack_next = 0;
        logic [31:0] hold_v = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (ack_next) begin
                chk("ack_width", ack, 2'b00);
                chk("rsp_hold", rsp_data, hold_v);
                ack_next = 0;
            end
            if (st_next) begin
                chk("start_width", wr.wr_start, 1'b0);
                st_next = 0;
            end
            if (rst_n && wr.wr_start) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_start: addr %0h with no pending transaction", wr.wr_addr);
                end else begin
                    chk("owner", owner, q[0].own);
                    chk("wr_addr", wr.wr_addr, q[0].a);
                    chk("wr_data", wr.wr_data, q[0].d);
                    chk("busy", busy, 1'b1);
                    t_start = cyc;
                    st_next = 1;
                end
            end
            if (rst_n && ack != 2'b00) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_ack: ack %b with no pending transaction", ack);
                end else begin
                    e = q.pop_front();
                    chk("ack_vec", ack, 2'b01 << e.own);
                    chk("rsp_data", rsp_data, e.rsp);
                    chk("rsp_err", rsp_err, e.err);
                    chk("ack_latency", cyc - t_start, e.off);
                    hold_v   = e.rsp;
                    ack_next = 1;
                end
            end
        end
    end

    initial begin
        int rel, n;
        repeat (2) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", wr.wr_start, 0);
        chk("rst_addr", wr.wr_addr, 0);
        chk("rst_rsp", {rsp_err, rsp_data}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        // single write, done 3 cycles after start
        req_addr = {8'h00, 8'h0E};
        req_data = {32'h0, 32'h12345678};
        push(0, 8'h0E, 32'h12345678, 3, 32'hCAFEF00D, 32'h0, 1'b0);
        req = 2'b01;
        wait_ack();
        req = 2'b00;
        // round-robin after reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req_addr = {8'h21, 8'h10};
        req_data = {32'h22222222, 32'h11111111};
        push(0, 8'h10, 32'h11111111, 2, 32'h0, 32'h0, 1'b0);
        push(1, 8'h21, 32'h22222222, 2, 32'h0, 32'h0, 1'b0);
        push(0, 8'h10, 32'h11111111, 2, 32'h0, 32'h0, 1'b0);
        push(1, 8'h21, 32'h22222222, 2, 32'h0, 32'h0, 1'b0);
        req = 2'b11;
        repeat (4) wait_ack();
        req = 2'b00;
        // strict priority for requester 0
        @(negedge clk);
        pri0 = 1'b1;
        req_addr = {8'h33, 8'h30};
        req_data = {32'h33333333, 32'h30303030};
        push(0, 8'h30, 32'h30303030, 4, 32'h0, 32'h0, 1'b0);
        push(1, 8'h33, 32'h33333333, 4, 32'h0, 32'h0, 1'b0);
        push(0, 8'h30, 32'h30303030, 4, 32'h0, 32'h0, 1'b0);
        push(1, 8'h33, 32'h33333333, 4, 32'h0, 32'h0, 1'b0);
        req = 2'b11;
        wait_ack();
        req = 2'b10;
        wait_ack();
        req = 2'b11;
        wait_ack();
        req = 2'b10;
        wait_ack();
        req = 2'b00;
        pri0 = 1'b0;
        // read returns writer data
        @(negedge clk);
        req_addr = {8'h00, 8'h8E};
        req_data = {32'h0, 32'h55555555};
        push(0, 8'h8E, 32'h55555555, 2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        req = 2'b01;
        wait_ack();
        req = 2'b00;
        // watchdog, then completion coinciding with the timeout
        @(negedge clk);
        req_addr = {8'h00, 8'h05};
        req_data = {32'h0, 32'hA0A0A0A0};
        push(0, 8'h05, 32'hA0A0A0A0, -1, 32'h0, 32'h0, 1'b1);
        req = 2'b01;
        wait_ack();
        req = 2'b00;
        @(negedge clk);
        req_addr = {8'h00, 8'h85};
        push(0, 8'h85, 32'hA0A0A0A0, 15, 32'h0BADF00D, 32'h0BADF00D, 1'b0);
        req = 2'b01;
        wait_ack();
        req = 2'b00;
        // reset in WAIT drops the transaction
        @(negedge clk);
        req_addr = {8'h66, 8'h00};
        req_data = {32'h66666666, 32'h0};
        push(1, 8'h66, 32'h66666666, -1, 32'h0, 32'h0, 1'b0);
        req = 2'b10;
        n = 0;
        while (!wr.wr_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", ack, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_owner", owner, 0);
        chk("mid_rst_addr", wr.wr_addr, 0);
        chk("mid_rst_data", wr.wr_data, 0);
        chk("mid_rst_rsp", {rsp_err, rsp_data}, 0);
        q.delete();
        push(1, 8'h66, 32'h66666666, 2, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rel = cyc;
        n = 0;
        while (!wr.wr_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_start", cyc - rel, 1);
        chk("post_rst_owner", owner, 1);
        wait_ack();
        req = 2'b00;
        repeat (5) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("idle_busy", busy, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
